// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Smallest r such that 2**r >= v (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Counter width able to hold 0 .. max(a,b,c)-1, never narrower than 1 bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low clear.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops; first may go metastable, second presents a settled value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock with a timeout and
// bounded retries, debounces lock and only then releases the downstream reset.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked_in,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_ok,
  output logic       fail,
  output logic [3:0] retry_count
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  // Terminal counts: the counter starts at 0 on state entry, so the last cycle is N-1.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  logic             w_locked_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_retry;
  logic [3:0]       w_retry_nxt;
  logic             r_pll_rst;
  logic             r_sys_reset_n;
  logic             r_lock_ok;
  logic             r_fail;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (locked_in),
    .o_q     (w_locked_s)
  );

  // Next-state decode; the counter is cleared on every transition so it never wraps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_retry_nxt = r_retry;
    case (r_state)
      ST_RESET_PLL: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock is tested first so a lock on the final timeout cycle still wins.
        if (w_locked_s) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_cnt_nxt = '0;
          if (r_retry == RETRY_MAX) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_state_nxt = ST_RESET_PLL;
            w_retry_nxt = r_retry + 4'd1;
          end
        end
      end
      ST_STABLE: begin
        // Losing lock while debouncing restarts the wait without spending a retry.
        if (!w_locked_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (!w_locked_s || relock_req) begin
          w_state_nxt = ST_RESET_PLL;
          w_retry_nxt = 4'd0;
        end
      end
      ST_FAIL: begin
        w_cnt_nxt = '0;
        if (relock_req) begin
          w_state_nxt = ST_RESET_PLL;
          w_retry_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt = ST_RESET_PLL;
        w_cnt_nxt   = '0;
        w_retry_nxt = 4'd0;
      end
    endcase
  end

  // State, counter and outputs register together; outputs decode the next state
  // so they switch on the same edge as the state and cannot glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RESET_PLL;
      r_cnt         <= '0;
      r_retry       <= 4'd0;
      r_pll_rst     <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_lock_ok     <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_retry       <= w_retry_nxt;
      r_pll_rst     <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAIL);
      r_sys_reset_n <= (w_state_nxt == ST_RUN);
      r_lock_ok     <= (w_state_nxt == ST_RUN);
      r_fail        <= (w_state_nxt == ST_FAIL);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_reset_n = r_sys_reset_n;
  assign lock_ok     = r_lock_ok;
  assign fail        = r_fail;
  assign retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Table-driven bench for pll_lock_supervisor with a scoreboard queue of expected outputs.
module tb_pll_lock_supervisor;

  localparam int RST  = 4;
  localparam int TMO  = 20;
  localparam int STB  = 8;
  localparam int MAXR = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       locked_in;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       lock_ok;
  logic       fail;
  logic [3:0] retry_count;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (RST),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .LOCK_STABLE_CYCLES  (STB),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .locked_in   (locked_in),
    .relock_req  (relock_req),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .lock_ok     (lock_ok),
    .fail        (fail),
    .retry_count (retry_count)
  );

  always #5 clk = ~clk;

  // One step: hold lk for cyc edges (rq only during the first), then optionally check.
  typedef struct {
    bit         chk;
    logic       lk;
    logic       rq;
    int         cyc;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Expected output word: {pll_rst, sys_reset_n, lock_ok, fail, retry_count}
  function automatic logic [7:0] pk(logic p, logic s, logic l, logic f, logic [3:0] r);
    return {p, s, l, f, r};
  endfunction

  function automatic void add(bit chk, logic lk, logic rq, int cyc, logic [7:0] e);
    vec_t v;
    v.chk = chk;
    v.lk  = lk;
    v.rq  = rq;
    v.cyc = cyc;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic compare(input string nm);
    logic [7:0] got;
    logic [7:0] e;
    got = {pll_rst, sys_reset_n, lock_ok, fail, retry_count};
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued, got %b", nm, got);
    end else begin
      e = sb_q.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got pll_rst=%b sys_reset_n=%b lock_ok=%b fail=%b retry=%0d, required pll_rst=%b sys_reset_n=%b lock_ok=%b fail=%b retry=%0d",
                 nm, got[7], got[6], got[5], got[4], got[3:0], e[7], e[6], e[5], e[4], e[3:0]);
      end
    end
  endtask

  task automatic apply(input int first, input int last);
    for (int i = first; i < last; i++) begin
      locked_in  = vecs[i].lk;
      relock_req = vecs[i].rq;
      if (vecs[i].chk) sb_q.push_back(vecs[i].exp);
      for (int c = 0; c < vecs[i].cyc; c++) begin
        @(posedge clk);
        #1;
        relock_req = 1'b0;
      end
      if (vecs[i].chk) compare($sformatf("vec%0d", i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int mark_main;

  initial begin
    // Phase A: lock held from reset -> RUN at edge 13.
    add(1, 1, 0, 3,  pk(1, 0, 0, 0, 0));  // edge 3, still pulsing
    add(1, 1, 0, 1,  pk(0, 0, 0, 0, 0));  // edge 4, WAIT_LOCK
    add(1, 1, 0, 8,  pk(0, 0, 0, 0, 0));  // edge 12, STABLE
    add(1, 1, 0, 1,  pk(0, 1, 1, 0, 0));  // edge 13, RUN
    add(1, 1, 0, 4,  pk(0, 1, 1, 0, 0));  // RUN holds
    // Phase B: lose lock in RUN, one timeout, lock lands on the timeout cycle,
    // glitch during STABLE, then RUN with retry_count=1.
    add(1, 0, 0, 3,  pk(1, 0, 0, 0, 0));  // R+3 RESET_PLL
    add(1, 0, 0, 3,  pk(1, 0, 0, 0, 0));  // R+6
    add(1, 0, 0, 1,  pk(0, 0, 0, 0, 0));  // R+7 WAIT_LOCK
    add(1, 0, 0, 19, pk(0, 0, 0, 0, 0));  // R+26 last waiting cycle
    add(1, 0, 0, 1,  pk(1, 0, 0, 0, 1));  // R+27 timeout -> retry 1
    add(1, 0, 0, 3,  pk(1, 0, 0, 0, 1));  // R+30
    add(1, 0, 0, 1,  pk(0, 0, 0, 0, 1));  // R+31 WAIT_LOCK
    add(1, 0, 0, 17, pk(0, 0, 0, 0, 1));  // R+48
    add(1, 1, 0, 2,  pk(0, 0, 0, 0, 1));  // R+50 lock raised, not yet seen
    add(1, 1, 0, 1,  pk(0, 0, 0, 0, 1));  // R+51 lock on timeout cycle wins
    add(1, 1, 0, 2,  pk(0, 0, 0, 0, 1));  // R+53 STABLE
    add(1, 0, 0, 3,  pk(0, 0, 0, 0, 1));  // R+56 glitch low
    add(1, 1, 0, 3,  pk(0, 0, 0, 0, 1));  // R+59 no RUN: debounce restarted
    add(1, 1, 0, 7,  pk(0, 0, 0, 0, 1));  // R+66
    add(1, 1, 0, 1,  pk(0, 1, 1, 0, 1));  // R+67 RUN, retry kept
    // Phase C: drop lock in RUN clears retry_count; relock reaches RUN 13 edges after entry.
    add(1, 0, 0, 3,  pk(1, 0, 0, 0, 0));  // Q+3
    add(1, 1, 0, 12, pk(0, 0, 0, 0, 0));  // Q+15
    add(1, 1, 0, 1,  pk(0, 1, 1, 0, 0));  // Q+16 RUN
    // Phase D: relock_req coincident with locked_s falling -> single 4-cycle pulse.
    add(0, 0, 0, 2,  pk(0, 1, 1, 0, 0));
    add(1, 0, 1, 1,  pk(1, 0, 0, 0, 0));  // T+3 RESET_PLL
    add(1, 0, 0, 3,  pk(1, 0, 0, 0, 0));  // T+6
    add(1, 0, 0, 1,  pk(0, 0, 0, 0, 0));  // T+7 WAIT_LOCK
    // relock_req during WAIT_LOCK ignored; then exhaust retries into FAIL.
    add(1, 0, 0, 2,  pk(0, 0, 0, 0, 0));  // V+2
    add(1, 0, 1, 1,  pk(0, 0, 0, 0, 0));  // V+3
    add(1, 0, 0, 16, pk(0, 0, 0, 0, 0));  // V+19
    add(1, 0, 0, 1,  pk(1, 0, 0, 0, 1));  // V+20
    add(1, 0, 0, 3,  pk(1, 0, 0, 0, 1));  // V+23
    add(1, 0, 0, 1,  pk(0, 0, 0, 0, 1));  // V+24
    add(1, 0, 0, 19, pk(0, 0, 0, 0, 1));  // V+43
    add(1, 0, 0, 1,  pk(1, 0, 0, 0, 2));  // V+44
    add(1, 0, 0, 3,  pk(1, 0, 0, 0, 2));  // V+47
    add(1, 0, 0, 1,  pk(0, 0, 0, 0, 2));  // V+48
    add(1, 0, 0, 19, pk(0, 0, 0, 0, 2));  // V+67
    add(1, 0, 0, 1,  pk(1, 0, 0, 1, 2));  // V+68 FAIL
    add(1, 1, 0, 10, pk(1, 0, 0, 1, 2));  // lock alone does not leave FAIL
    add(1, 1, 1, 1,  pk(1, 0, 0, 0, 0));  // E relock_req exits FAIL
    add(1, 1, 0, 3,  pk(1, 0, 0, 0, 0));  // E+3
    add(1, 1, 0, 1,  pk(0, 0, 0, 0, 0));  // E+4
    add(1, 1, 0, 8,  pk(0, 0, 0, 0, 0));  // E+12
    add(1, 1, 0, 1,  pk(0, 1, 1, 0, 0));  // E+13 RUN
    // Phase E: drive into STABLE for the asynchronous reset check.
    add(1, 0, 0, 3,  pk(1, 0, 0, 0, 0));  // E+16
    add(1, 1, 0, 5,  pk(0, 0, 0, 0, 0));  // E+21 STABLE
    add(1, 1, 0, 2,  pk(0, 0, 0, 0, 0));  // E+23 mid-STABLE
    mark_main = vecs.size();
    // After the asynchronous reset: same release timing as the first power-up.
    add(1, 1, 0, 3,  pk(1, 0, 0, 0, 0));
    add(1, 1, 0, 1,  pk(0, 0, 0, 0, 0));
    add(1, 1, 0, 8,  pk(0, 0, 0, 0, 0));
    add(1, 1, 0, 1,  pk(0, 1, 1, 0, 0));

    reset_n    = 1'b0;
    locked_in  = 1'b1;
    relock_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_q.push_back(pk(1, 0, 0, 0, 0));
    compare("reset_values");
    reset_n = 1'b1;

    apply(0, mark_main);

    // Asynchronous reset mid-STABLE: outputs must change before the next edge.
    #2;
    reset_n = 1'b0;
    #1;
    sb_q.push_back(pk(1, 0, 0, 0, 0));
    compare("async_reset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    apply(mark_main, vecs.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
